// File: rtl/wb_pipe_stage_pkg.sv
// Shared definitions for the MEM->WB stage: default widths, packed entry
// layout {read_data, alu_result, dest, reg_write, mem_to_reg} and occupancy states.
package wb_pipe_stage_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned RADDR_W_DEF = 5;

    localparam int unsigned OFS_MEM_TO_REG = 0;
    localparam int unsigned OFS_REG_WRITE  = 1;
    localparam int unsigned OFS_DEST       = 2;

    function automatic int unsigned ofs_alu_result(input int unsigned raddr_w);
        return OFS_DEST + raddr_w;
    endfunction

    function automatic int unsigned ofs_read_data(input int unsigned data_w,
                                                  input int unsigned raddr_w);
        return OFS_DEST + raddr_w + data_w;
    endfunction

    function automatic int unsigned entry_width(input int unsigned data_w,
                                                input int unsigned raddr_w);
        return 2 * data_w + raddr_w + 2;
    endfunction

    // Encoding equals the number of entries held, so it doubles as occupancy.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/wb_pipe_stage_skid_buf2.sv
// Generic WIDTH-bit two-entry skid buffer with flush; in_ready is registered
// so the upstream never sees a combinational path from out_ready.
module skid_buf2
    import wb_pipe_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    occ_state_t       state_q;
    occ_state_t       state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             accept;
    logic             retire;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;

    assign accept = in_valid & in_ready_q;
    assign retire = (state_q != OCC_EMPTY) & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_FULL);
            if (load_head_in) begin
                head_q <= in_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    // Flush wins over any accept/retire; head contents are left untouched.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d      = OCC_ONE;
                        load_head_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && retire) begin
                        state_d      = OCC_ONE;
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_d   = OCC_FULL;
                        load_skid = 1'b1;
                    end else if (retire) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (retire) begin
                        state_d        = OCC_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q != OCC_EMPTY);
        out_data  = head_q;
        occupancy = state_q;
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage: packs the MEM fields into one entry, buffers it in a
// two-entry skid buffer and selects the register-file write-back value.
module wb_pipe_stage
    import wb_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_read_data,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [RADDR_W-1:0] in_dest,
    input  logic               in_reg_write,
    input  logic               in_mem_to_reg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_read_data,
    output logic [DATA_W-1:0]  out_alu_result,
    output logic [RADDR_W-1:0] out_dest,
    output logic               out_reg_write,
    output logic               out_mem_to_reg,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic [1:0]         occupancy
);

    localparam int unsigned ENTRY_W = entry_width(DATA_W, RADDR_W);
    localparam int unsigned OFS_ALU = ofs_alu_result(RADDR_W);
    localparam int unsigned OFS_RD  = ofs_read_data(DATA_W, RADDR_W);

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head;
    logic               head_valid;

    assign in_entry = {in_read_data, in_alu_result, in_dest, in_reg_write, in_mem_to_reg};

    skid_buf2 #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (head_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .occupancy (occupancy)
    );

    // reg_write is gated so an empty stage can never write the register file.
    always_comb begin
        out_valid      = head_valid;
        out_read_data  = head[OFS_RD +: DATA_W];
        out_alu_result = head[OFS_ALU +: DATA_W];
        out_dest       = head[OFS_DEST +: RADDR_W];
        out_reg_write  = head_valid & head[OFS_REG_WRITE];
        out_mem_to_reg = head[OFS_MEM_TO_REG];
        out_wb_data    = head[OFS_MEM_TO_REG] ? head[OFS_RD +: DATA_W]
                                              : head[OFS_ALU +: DATA_W];
    end

endmodule
